// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32 instruction encoder.
//   - fmt_e      : request format codes (I, S, U, LI pseudo-op)
//   - OP_*       : RV32 base opcodes used by the encoder and its callers
//   - fits_simm12: true when a 32-bit value is representable as a signed 12-bit immediate
//   - pack_i/s/u : bit-exact field packing for the I, S and U instruction formats
package rv_enc_pkg;

   typedef enum logic [1:0] {
      FMT_I  = 2'b00,
      FMT_S  = 2'b01,
      FMT_U  = 2'b10,
      FMT_LI = 2'b11
   } fmt_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   // A value fits in simm12 when bits 31..11 are all copies of the sign bit.
   function automatic logic fits_simm12(input logic [31:0] imm);
      return (imm[31:11] == '0) || (imm[31:11] == '1);
   endfunction

   function automatic logic [31:0] pack_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                          input logic [2:0] funct3, input logic [4:0] rd,
                                          input logic [6:0] opcode);
      return {imm12, rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [31:0] pack_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] funct3,
                                          input logic [6:0] opcode);
      return {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
   endfunction

   function automatic logic [31:0] pack_u(input logic [19:0] imm20, input logic [4:0] rd,
                                          input logic [6:0] opcode);
      return {imm20, rd, opcode};
   endfunction

endpackage

// File: rtl/inst_fields_pack.sv
// Combinational field packer for inst_encoder.
// Inputs : fmt, opcode, funct3, rd, rs1, rs2, imm (raw request fields)
// Outputs: word1    - first (or only) instruction word
//          word2    - second word of a two-word LI (ADDI rd,rd,lo), else 0
//          two_word - request expands to LUI+ADDI
//          imm_err  - immediate out of range for the selected format
module inst_fields_pack
   import rv_enc_pkg::*;
#(
   parameter bit LI_EN    = 1'b1,
   parameter bit ZERO_BAD = 1'b1
) (
   input  logic [1:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word1,
   output logic [31:0] word2,
   output logic        two_word,
   output logic        imm_err
);

   logic        in_range;
   logic [11:0] imm12;
   logic [19:0] li_hi;

   assign in_range = fits_simm12(imm);
   assign imm12    = (ZERO_BAD && !in_range) ? 12'h000 : imm[11:0];
   // (imm + 0x800) >> 12 without a 32-bit adder: the +0x800 only carries into
   // bit 12 when imm[11] is set. The 20-bit add wraps mod 2^32 as required.
   assign li_hi    = imm[31:12] + {19'd0, imm[11]};

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      word1    = '0;
      word2    = '0;
      two_word = 1'b0;
      imm_err  = 1'b0;
      case (fmt_e'(fmt))
         FMT_I: begin
            word1   = pack_i(imm12, rs1, funct3, rd, opcode);
            imm_err = !in_range;
         end
         FMT_S: begin
            word1   = pack_s(imm12, rs2, rs1, funct3, opcode);
            imm_err = !in_range;
         end
         FMT_U: begin
            // Low 12 bits have no field in a U word; they are dropped either way.
            word1   = pack_u(imm[31:12], rd, opcode);
            imm_err = (imm[11:0] != 12'h000);
         end
         FMT_LI: begin
            if (!LI_EN) begin
               imm_err = 1'b1;
            end else if (in_range) begin
               word1 = pack_i(imm[11:0], 5'd0, 3'b000, rd, OP_IMM);
            end else begin
               // ADDI sign-extends lo, so hi is pre-rounded to compensate.
               word1    = pack_u(li_hi, rd, OP_LUI);
               word2    = pack_i(imm[11:0], rd, 3'b000, rd, OP_IMM);
               two_word = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction encoder with valid/ready handshakes on both sides.
// Packs I/S/U requests into one word and expands LI into ADDI or LUI+ADDI.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   InValid/InReady      - request handshake (InReady combinational from OutReady)
//   Fmt, Opcode, Funct3,
//   Rd, Rs1, Rs2, Imm    - request fields, sampled on acceptance only
//   OutValid/OutReady    - instruction word handshake
//   InstCode             - registered instruction word
//   Last                 - final word of the current request
//   ImmErr               - one-cycle pulse, aligned with the first output word of an
//                          out-of-range request
module inst_encoder
   import rv_enc_pkg::*;
#(
   parameter bit LI_EN    = 1'b1,
   parameter bit ZERO_BAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        InValid,
   output logic        InReady,
   input  logic [1:0]  Fmt,
   input  logic [6:0]  Opcode,
   input  logic [2:0]  Funct3,
   input  logic [4:0]  Rd,
   input  logic [4:0]  Rs1,
   input  logic [4:0]  Rs2,
   input  logic [31:0] Imm,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] InstCode,
   output logic        Last,
   output logic        ImmErr
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      HOLD     = 2'b01,
      HOLD_LI1 = 2'b10
   } state_e;

   state_e      state, state_next;
   logic [31:0] word1, word2, pending;
   logic        two_word, imm_err;
   logic        accept, load_new, drop_req;

   inst_fields_pack #(
      .LI_EN   (LI_EN),
      .ZERO_BAD(ZERO_BAD)
   ) u_pack (
      .fmt     (Fmt),
      .opcode  (Opcode),
      .funct3  (Funct3),
      .rd      (Rd),
      .rs1     (Rs1),
      .rs2     (Rs2),
      .imm     (Imm),
      .word1   (word1),
      .word2   (word2),
      .two_word(two_word),
      .imm_err (imm_err)
   );

   // rst_n gates InReady because the state register already reads IDLE during reset.
   assign InReady  = rst_n && ((state == IDLE) || (state == HOLD && OutReady));
   assign accept   = InValid && InReady;
   // A disabled LI is accepted and flagged but produces no word.
   assign drop_req = (fmt_e'(Fmt) == FMT_LI) && imm_err;
   assign load_new = accept && !drop_req;
   assign OutValid = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (load_new) state_next = two_word ? HOLD_LI1 : HOLD;
         HOLD:     if (OutReady) state_next = load_new ? (two_word ? HOLD_LI1 : HOLD) : IDLE;
         HOLD_LI1: if (OutReady) state_next = HOLD;
         default:  state_next = IDLE;
      endcase
   end

   // NOTE: the pending word is reset like any other register, so a reset
   // in the middle of an LI pair cannot leak its second word afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         InstCode <= '0;
         Last     <= 1'b0;
         ImmErr   <= 1'b0;
         pending  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state  <= state_next;
         ImmErr <= accept && imm_err;
         if (load_new) begin
            InstCode <= word1;
            Last     <= !two_word;
            pending  <= word2;
         end else if (state == HOLD_LI1 && OutReady) begin
            InstCode <= pending;
            Last     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases, then randomized traffic
// with random backpressure compared against an arithmetic reference model.
module tb_inst_encoder;

   logic        clk;
   logic        rst_n;
   logic        InValid;
   logic        InReady;
   logic [1:0]  Fmt;
   logic [6:0]  Opcode;
   logic [2:0]  Funct3;
   logic [4:0]  Rd;
   logic [4:0]  Rs1;
   logic [4:0]  Rs2;
   logic [31:0] Imm;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] InstCode;
   logic        Last;
   logic        ImmErr;

   int n_checks;
   int n_errors;

   logic [32:0] exp_q[$];
   logic [32:0] e;
   logic [31:0] w0, w1, held_code;
   logic        m_err, err_due, acc, held;
   int          n_words;
   logic [31:0] edge_imm [8] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                 32'h7FFFF800, 32'h7FFFFFFF, 32'h80000000, 32'h00000800};

   inst_encoder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .InValid (InValid),
      .InReady (InReady),
      .Fmt     (Fmt),
      .Opcode  (Opcode),
      .Funct3  (Funct3),
      .Rd      (Rd),
      .Rs1     (Rs1),
      .Rs2     (Rs2),
      .Imm     (Imm),
      .OutValid(OutValid),
      .OutReady(OutReady),
      .InstCode(InstCode),
      .Last    (Last),
      .ImmErr  (ImmErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: words derived from RV32 field positions with plain arithmetic.
   function automatic int model(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output logic [31:0] o0,
                                output logic [31:0] o1, output logic err);
      int          s;
      bit          fits;
      logic [31:0] fld, lo, upper;
      int          n;
      s    = $signed(imm);
      fits = (s >= -2048) && (s <= 2047);
      fld  = fits ? (imm & 32'hFFF) : 32'h0;
      o0   = '0;
      o1   = '0;
      err  = 1'b0;
      n    = 1;
      case (fmt)
         2'd0: begin
            o0  = (fld << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
            err = !fits;
         end
         2'd1: begin
            o0  = ((fld >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                | ((fld & 32'h1F) << 7) | 32'(op);
            err = !fits;
         end
         2'd2: begin
            o0  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            err = ((imm & 32'hFFF) != 0);
         end
         default: begin
            if (fits) begin
               o0 = ((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13;
            end else begin
               // LUI value is whatever remains after the sign-extended ADDI part.
               lo    = imm & 32'hFFF;
               upper = imm - ((lo ^ 32'h800) - 32'h800);
               o0    = upper | (32'(rd) << 7) | 32'h37;
               o1    = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
               n     = 2;
            end
         end
      endcase
      return n;
   endfunction

   task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
      Fmt = f; Opcode = op; Funct3 = f3; Rd = rd; Rs1 = rs1; Rs2 = rs2; Imm = imm;
      InValid = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input string tag, input logic [1:0] f, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
      bit got;
      got = 1'b0;
      drive(f, op, f3, rd, rs1, rs2, imm);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (InReady) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!got) check({tag, "_accept_timeout"}, 32'(InReady), 32'd1);
      @(posedge clk); #1;
      InValid = 1'b0;
   endtask

   // Requires OutReady=1; waits for a word, checks it, lets it be consumed.
   task automatic expect_word(input string tag, input logic [31:0] code, input logic last,
                              input logic err);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (OutValid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check({tag, "_valid_timeout"}, 32'(OutValid), 32'd1);
      check({tag, "_code"}, InstCode, code);
      check({tag, "_last"}, 32'(Last), 32'(last));
      check({tag, "_immerr"}, 32'(ImmErr), 32'(err));
      @(posedge clk); #1;
   endtask

   task automatic random_request();
      int sel;
      Fmt    = 2'($urandom_range(0, 3));
      Opcode = 7'($urandom);
      Funct3 = 3'($urandom);
      Rd     = 5'($urandom_range(0, 31));
      Rs1    = 5'($urandom_range(0, 31));
      Rs2    = 5'($urandom_range(0, 31));
      sel    = $urandom_range(0, 4);
      case (sel)
         0:       Imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         1:       Imm = edge_imm[$urandom_range(0, 7)];
         2:       Imm = $urandom & 32'hFFFFF000;
         default: Imm = $urandom;
      endcase
      InValid = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      Fmt = '0; Opcode = '0; Funct3 = '0; Rd = '0; Rs1 = '0; Rs2 = '0; Imm = '0;

      // Reset state
      #12;
      check("rst_outvalid", 32'(OutValid), 32'd0);
      check("rst_instcode", InstCode, 32'd0);
      check("rst_last", 32'(Last), 32'd0);
      check("rst_immerr", 32'(ImmErr), 32'd0);
      check("rst_inready", 32'(InReady), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_inready", 32'(InReady), 32'd1);
      @(posedge clk); #1;

      // Directed format cases
      issue("i", 2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC);
      expect_word("i", 32'hFFC12283, 1'b1, 1'b0);
      issue("s", 2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'd8);
      expect_word("s", 32'h00612423, 1'b1, 1'b0);
      issue("u", 2'b10, 7'b0010111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h12345000);
      expect_word("u", 32'h12345097, 1'b1, 1'b0);
      issue("u_err", 2'b10, 7'b0010111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h12345678);
      expect_word("u_err", 32'h12345097, 1'b1, 1'b1);
      issue("li_small", 2'b11, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'd5);
      expect_word("li_small", 32'h00500513, 1'b1, 1'b0);
      issue("li_big", 2'b11, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      expect_word("li_big_w1", 32'h12346537, 1'b0, 1'b0);
      expect_word("li_big_w2", 32'hFFF50513, 1'b1, 1'b0);

      // Range error with zeroed immediate; pulse lasts one cycle
      issue("i_err", 2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'd2048);
      expect_word("i_err", 32'h00012283, 1'b1, 1'b1);
      @(negedge clk);
      check("i_err_pulse_end", 32'(ImmErr), 32'd0);
      @(posedge clk); #1;

      // Back-to-back acceptance at full throughput
      issue("b2b_a", 2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC);
      drive(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'd8);
      @(negedge clk);
      check("b2b_a_code", InstCode, 32'hFFC12283);
      check("b2b_inready", 32'(InReady), 32'd1);
      @(posedge clk); #1;
      InValid = 1'b0;
      @(negedge clk);
      check("b2b_b_valid", 32'(OutValid), 32'd1);
      check("b2b_b_code", InstCode, 32'h00612423);
      @(posedge clk); #1;

      // Backpressure during an LI pair
      OutReady = 1'b0;
      issue("li_bp", 2'b11, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("li_bp_valid", 32'(OutValid), 32'd1);
         check("li_bp_code", InstCode, 32'h12346537);
         check("li_bp_last", 32'(Last), 32'd0);
         check("li_bp_inready", 32'(InReady), 32'd0);
         @(posedge clk); #1;
      end
      OutReady = 1'b1;
      @(negedge clk);
      check("li_bp_w1_code", InstCode, 32'h12346537);
      @(posedge clk); #1;
      @(negedge clk);
      check("li_bp_w2_valid", 32'(OutValid), 32'd1);
      check("li_bp_w2_code", InstCode, 32'hFFF50513);
      check("li_bp_w2_last", 32'(Last), 32'd1);
      @(posedge clk); #1;

      // Reset while the second LI word is pending
      OutReady = 1'b0;
      issue("li_rst", 2'b11, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      @(negedge clk);
      check("li_rst_pre_valid", 32'(OutValid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("li_rst_valid", 32'(OutValid), 32'd0);
      check("li_rst_inready", 32'(InReady), 32'd0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      OutReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("li_rst_no_w2", 32'(OutValid), 32'd0);
         @(posedge clk); #1;
      end
      issue("post_rst", 2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC);
      expect_word("post_rst", 32'hFFC12283, 1'b1, 1'b0);

      // Randomized traffic with random backpressure, then a drain phase
      acc     = 1'b0;
      err_due = 1'b0;
      held    = 1'b0;
      held_code = '0;
      for (int i = 0; i < 420; i++) begin
         if (i >= 400) begin
            InValid  = 1'b0;
            OutReady = 1'b1;
         end else begin
            if (acc || !InValid) begin
               if ($urandom_range(0, 3) != 0) random_request();
               else InValid = 1'b0;
            end
            OutReady = ($urandom_range(0, 3) != 0);
         end
         @(negedge clk);
         check("rnd_immerr", 32'(ImmErr), 32'(err_due));
         if (held) begin
            check("rnd_hold_valid", 32'(OutValid), 32'd1);
            check("rnd_hold_code", InstCode, held_code);
         end
         held      = OutValid && !OutReady;
         held_code = InstCode;
         if (OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
               check("rnd_spurious", 32'(OutValid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rnd_code", InstCode, e[31:0]);
               check("rnd_last", 32'(Last), 32'(e[32]));
            end
         end
         acc     = InValid && InReady;
         err_due = 1'b0;
         if (acc) begin
            n_words = model(Fmt, Opcode, Funct3, Rd, Rs1, Rs2, Imm, w0, w1, m_err);
            err_due = m_err;
            exp_q.push_back({(n_words == 1), w0});
            if (n_words == 2) exp_q.push_back({1'b1, w1});
         end
         @(posedge clk); #1;
      end
      check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
